// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, response codes and access-size constants for the data-memory controller.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_timeout.sv
// dmem_timeout: saturating wait counter that flags expiry at TIMEOUT_CYCLES (0 disables).
module dmem_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller bridging the core to a valid/ready data-memory bus.
module dmem_ctrl import dmem_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);
  state_e state;
  logic expired;
  logic unused_f3;
  assign unused_f3 = req_funct3[2];
  assign req_ready = state == IDLE;
  assign stall = req_valid | (state != IDLE);
  dmem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timeout (
    .clk(clk),
    .resetn(resetn),
    .clr(state != BUS),
    .en(mem_valid & ~mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      mem_valid <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= ERR_OK;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        if (misaligned(req_funct3[1:0], req_addr[1:0])) begin
          rsp_err <= ERR_MISALIGN;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          mem_valid <= 1'b1;
          mem_we <= req_we;
          mem_addr <= {req_addr[31:2], 2'b00};
          mem_wdata <= req_wdata;
          mem_wstrb <= req_we ? req_wmask : 4'b0000;
          state <= BUS;
        end
      end else if (state == BUS && (mem_ready || expired)) begin
        // a handshake landing on the expiry cycle still completes normally
        mem_valid <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err <= mem_ready ? (mem_err ? ERR_BUS : ERR_OK) : ERR_TIMEOUT;
        rsp_rdata <= (mem_ready && !mem_err && !mem_we) ? mem_rdata : '0;
        state <= RESP;
      end else if (state == RESP) state <= IDLE;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized transactions checked against a transaction-level model of the controller.
module tb_dmem_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic resetn;
  logic req_valid, req_ready, req_we, stall, rsp_valid;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] req_wmask, mem_wstrb;
  logic [2:0] req_funct3;
  logic [1:0] rsp_err;
  logic mem_valid, mem_ready, mem_we, mem_err;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]  mv;
    logic [7:0]  lat;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        stable;
    logic        busy_ok;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [7:0]  pulses;
    logic        ready_after;
    logic [31:0] rdata_hold;
  } txn_t;

  dmem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_funct3(req_funct3), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Expected outcome of one transaction; delay = cycles the bus keeps mem_ready low.
  function automatic txn_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wmask, input logic [2:0] f3, input int delay,
                                 input logic merr, input logic [31:0] mrdata);
    txn_t e;
    logic mis, to;
    e = '0;
    mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    to = delay > TO;
    e.stable = 1'b1;
    e.busy_ok = 1'b1;
    e.pulses = 8'd1;
    e.ready_after = 1'b1;
    if (mis) begin
      e.lat = 8'd1;
      e.err = 2'b01;
    end else begin
      e.mv = 8'(to ? TO + 1 : delay + 1);
      e.lat = e.mv + 8'd1;
      e.we = we;
      e.addr = {addr[31:2], 2'b00};
      e.wdata = wdata;
      e.strb = we ? wmask : 4'b0000;
      e.err = to ? 2'b11 : (merr ? 2'b10 : 2'b00);
      e.rdata = (!to && !merr && !we) ? mrdata : 32'h0;
    end
    e.rdata_hold = e.rdata;
    return e;
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [2:0] f3, input int delay,
                         input logic merr, input logic [31:0] mrdata, output txn_t o);
    int c;
    c = 0;
    o = '0;
    o.stable = 1'b1;
    o.busy_ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_funct3 = f3;
    @(negedge clk);
    for (int k = 1; k <= 12; k++) begin
      if (mem_valid) begin
        c++;
        o.mv++;
        if (c == 1) begin
          o.we = mem_we;
          o.addr = mem_addr;
          o.wdata = mem_wdata;
          o.strb = mem_wstrb;
        end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {o.we, o.addr, o.wdata, o.strb})
          o.stable = 1'b0;
      end
      if ((mem_valid || rsp_valid) && (stall !== 1'b1 || req_ready !== 1'b0)) o.busy_ok = 1'b0;
      if (rsp_valid) begin
        o.pulses++;
        if (o.lat == 0) begin
          o.lat = 8'(k);
          o.rdata = rsp_rdata;
          o.err = rsp_err;
        end
      end
      if (o.lat != 0 && k == int'(o.lat) + 1) o.ready_after = req_ready;
      mem_ready = mem_valid && c == delay + 1;
      mem_err = mem_ready ? merr : 1'($urandom);
      mem_rdata = mem_ready ? mrdata : $urandom;
      // garbage requests while the bus is busy must be ignored
      req_valid = mem_valid;
      req_we = 1'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      req_wmask = 4'($urandom);
      req_funct3 = 3'($urandom);
      @(negedge clk);
    end
    o.rdata_hold = rsp_rdata;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wmask = '0;
    req_funct3 = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got mv=%b we=%b addr=%h wd=%h strb=%b rv=%b rd=%h err=%b required all zero",
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid, rsp_rdata, rsp_err);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, stall} !== 2'b10) begin
      failures++;
      $display("FAIL reset_idle got req_ready=%b stall=%b required 1 0", req_ready, stall);
    end
    req_valid = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL stall_on_req got %b required 1", stall);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_directed(input string name, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wmask, input logic [2:0] f3,
                               input int delay, input logic merr, input logic [31:0] mrdata);
    txn_t o, e;
    e = model(we, addr, wdata, wmask, f3, delay, merr, mrdata);
    run_txn(we, addr, wdata, wmask, f3, delay, merr, mrdata, o);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL %s got %p required %p", name, o, e);
    end
  endtask

  task automatic test_load_word;
    test_directed("load_word", 1'b0, 32'h0000_1004, 32'h0, 4'b0000, 3'b010, 0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_store_byte;
    test_directed("store_byte", 1'b1, 32'h0000_2003, 32'h5A5A_5A5A, 4'b1000, 3'b000, 3, 1'b0, 32'h7777_7777);
  endtask

  task automatic test_misaligned;
    test_directed("misaligned_half", 1'b0, 32'h0000_3001, 32'h0, 4'b0000, 3'b001, 0, 1'b0, 32'h1111_1111);
    test_directed("misaligned_word", 1'b1, 32'h0000_3006, 32'hCAFE_F00D, 4'b1111, 3'b010, 0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout;
    test_directed("timeout", 1'b0, 32'h0000_4000, 32'h0, 4'b0000, 3'b010, 10, 1'b0, 32'hABCD_0123);
    test_directed("ready_at_expiry", 1'b0, 32'h0000_4008, 32'h0, 4'b0000, 3'b010, TO, 1'b0, 32'hABCD_0123);
  endtask

  task automatic test_bus_err;
    test_directed("bus_err", 1'b0, 32'h0000_5000, 32'h0, 4'b0000, 3'b010, 1, 1'b1, 32'h1234_5678);
  endtask

  task automatic test_reset_mid;
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h0000_6000;
    req_funct3 = 3'b010;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_bus got mem_valid=%b required 1", mem_valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({mem_valid, rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_drop got mem_valid=%b rsp_valid=%b required 0 0", mem_valid, rsp_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_release got spurious activity, required idle with req_ready=1");
    end
    test_directed("after_reset_load", 1'b0, 32'h0000_6004, 32'h0, 4'b0000, 3'b010, 0, 1'b0, 32'h0BAD_CAFE);
    test_directed("after_reset_store", 1'b1, 32'h0000_6009, 32'h3C3C_3C3C, 4'b0110, 3'b001, 2, 1'b0, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic we, merr;
      logic [31:0] addr, wdata, mrdata;
      logic [3:0] wmask;
      logic [2:0] f3;
      int delay;
      we = 1'($urandom);
      addr = $urandom;
      wdata = $urandom;
      mrdata = $urandom;
      wmask = 4'($urandom);
      f3 = {1'($urandom), 2'($urandom_range(0, 2))};
      delay = $urandom_range(0, 6);
      merr = ($urandom_range(0, 3) == 0);
      test_directed($sformatf("random_%0d", i), we, addr, wdata, wmask, f3, delay, merr, mrdata);
    end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_store_byte;
    test_misaligned;
    test_timeout;
    test_bus_err;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller directly downstream of the load/store alignment unit. It accepts one formatted load/store request per transaction: word-aligned address, replicated write data, byte mask and funct3. It runs a valid/ready handshake with the data-memory bus and returns the raw 32-bit read word, which feeds back to the alignment unit's read-data input. It also detects misaligned accesses, bus errors and bus timeouts, and holds the core in stall while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_valid may stay high without mem_ready; 0 disables the timeout
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  single system clock, rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  full byte address
req_wdata  input  32  store data, already lane-replicated
req_wmask  input  4  store byte mask
req_funct3  input  3  access size/sign field
stall  output  1  core must hold pipeline
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  raw memory word for loads; 0 for stores and errors
rsp_err  output  2  00 ok, 01 misaligned, 10 bus error, 11 timeout
mem_valid  output  1  bus request
mem_ready  input  1  bus accepts/completes the request
mem_we  output  1  bus write enable
mem_addr  output  32  {req_addr[31:2],2'b00}
mem_wdata  output  32  registered req_wdata
mem_wstrb  output  4  registered req_wmask on stores; 4'b0000 on loads
mem_rdata  input  32  bus read data, valid with mem_ready
mem_err  input  1  bus error, sampled only with mem_ready

Behaviour:
- Reset (async, resetn=0): state IDLE. mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, counter=0. req_ready=1 and stall=0 once resetn=1.
- Reset asserted mid-transaction: mem_valid drops immediately and the transaction is abandoned. No rsp_valid is issued.
- req_ready = (state==IDLE). stall = req_valid | (state!=IDLE).
- Misaligned: funct3[1:0]==01 with addr[0]=1, or funct3[1:0]==10 with addr[1:0]!=00.
- FSM states: IDLE, BUS, RESP.
- IDLE, accept (req_valid&req_ready) at edge N:
  - aligned: register addr/wdata/wstrb/we, mem_valid=1 from cycle N+1, go BUS.
  - misaligned: no bus cycle, rsp_err=01, go RESP.
- BUS: mem_valid and all mem_* outputs held stable until handshake. Counter increments each cycle mem_valid=1 && mem_ready=0.
  - mem_ready=1 at edge: mem_valid=0 next cycle. Capture rsp_rdata=mem_rdata (loads, no error), else 0. rsp_err = mem_err ? 10 : 00. Go RESP.
  - counter==TIMEOUT_CYCLES and mem_ready=0 (TIMEOUT_CYCLES>0): drop mem_valid, rsp_err=11, rsp_rdata=0, go RESP.
  - mem_ready and timeout expiry in the same cycle: mem_ready wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_err hold until the next RESP. Counter cleared.
- Latency with zero-wait memory: accept at N, mem_valid N+1, rsp_valid N+2, req_ready again N+3. Misaligned: rsp_valid N+1.
- req_* inputs are ignored outside IDLE. Only one transaction is outstanding.

Decomposition:
- Shared package (dmem_pkg): state encoding IDLE/BUS/RESP; rsp_err codes ERR_OK/ERR_MISALIGN/ERR_BUS/ERR_TIMEOUT; funct3 size constants SZ_B=00, SZ_H=01, SZ_W=10.
- One sub-module: dmem_timeout. Saturating counter with clear/enable, CNT_W wide, outputs expired when count==TIMEOUT_CYCLES and TIMEOUT_CYCLES!=0.

Test Plan:
- Load word, addr 0x0000_1004, memory returns 0xDEAD_BEEF with mem_ready at first cycle -> mem_addr=0x1004, mem_wstrb=0000, rsp_valid at N+2, rsp_rdata=0xDEADBEEF, rsp_err=00.
- Store byte, addr 0x0000_2003, wdata 0x5A5A5A5A, wmask 1000, mem_ready delayed 3 cycles -> mem_valid/mem_addr=0x2000/mem_wstrb=1000 stable for 4 cycles, rsp_valid once, rsp_rdata=0, rsp_err=00.
- Load half, addr 0x0000_3001 -> mem_valid never asserts, rsp_valid at N+1, rsp_err=01.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high 5 cycles then drops, rsp_err=11; mem_ready rising at the expiry cycle instead -> rsp_err=00 with data captured.
- Load with mem_err=1 alongside mem_ready, rdata 0x1234_5678 -> rsp_err=10, rsp_rdata=0.
- resetn pulsed low while in BUS -> mem_valid=0 asynchronously, no rsp_valid, req_ready=1 after release; a back-to-back request afterwards completes normally.
